string_hw_host_if: RTL and testbench
====================================

STRING_HW_HOST_IF -- requirements
Module: string_hw_host_if

Interface
REQ-001 The module SHALL have the following parameters:
- MAX_BLOCKS, default 2, number of 4-byte string blocks per operand; legal range 1..4.
- TIMEOUT_CYCLES, default 1024, maximum number of cycles to wait for accelerator done.

REQ-002 The module SHALL have the following ports, clock and reset first:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  4  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, registered.
- irq  out  1  interrupt request, level.
- go  out  1  start request to the accelerator.
- index  out  4  operation select to the accelerator.
- A  out  MAX_BLOCKS*4 x 8  operand A, byte 0 = first character.
- B  out  MAX_BLOCKS*4 x 8  operand B.
- done  in  1  accelerator completion.
- Result  in  MAX_BLOCKS*4 x 8  accelerator result.

Function
REQ-003 Register map (word addresses) SHALL be:
- 0 CTRL: write bit0 = start (self-clearing), bit1 = irq_en; read returns bit0 = busy, bit1 = irq_en.
- 1 STATUS: bit0 = done_flag, bit1 = timeout_flag; each bit is write-1-to-clear.
- 2 INDEX: bits [3:0].
- 4 .. 4+MAX_BLOCKS-1: A words.
- 4+MAX_BLOCKS .. 4+2*MAX_BLOCKS-1: B words.
- 4+2*MAX_BLOCKS .. 4+3*MAX_BLOCKS-1: R words, read-only.
REQ-004 Word k of A, B and R SHALL map byte 4k to bits [31:24] and byte 4k+3 to bits [7:0].
REQ-005 avs_readdata SHALL be valid exactly one cycle after avs_read; unmapped addresses SHALL read 0 and ignore writes.
REQ-006 The FSM SHALL have states IDLE, RUN, RELEASE.
- IDLE -> RUN on a CTRL write with bit0=1.
- RUN -> RELEASE on done=1 or on timeout.
- RELEASE -> IDLE when done=0.
REQ-007 In RUN, go SHALL be 1, asserted the cycle after the start write; in IDLE and RELEASE, go SHALL be 0.
REQ-008 On the RUN->RELEASE transition caused by done=1, the block SHALL capture Result into the R registers and set done_flag.
REQ-009 A cycle counter SHALL clear on entry to RUN and increment each RUN cycle. On reaching TIMEOUT_CYCLES without done, the block SHALL set timeout_flag, leave R unchanged, and enter RELEASE.
REQ-010 If done=1 in the same cycle the counter reaches TIMEOUT_CYCLES, done SHALL win: R is captured, done_flag is set, timeout_flag is not set.
REQ-011 busy SHALL be 1 in RUN and RELEASE.
REQ-012 While busy, the block SHALL ignore writes to INDEX, A, B and the CTRL start bit; irq_en writes and STATUS clears SHALL still take effect.
REQ-013 A start written while done_flag or timeout_flag is set SHALL be accepted; the flags are left unchanged until software clears them.
REQ-014 irq SHALL equal irq_en AND (done_flag OR timeout_flag), registered.
REQ-015 A STATUS write-1-to-clear in the same cycle as a flag set SHALL leave the flag set.
REQ-016 index, A and B outputs SHALL be driven directly from their registers and SHALL be stable for the whole time go=1.

Reset
REQ-017 When reset_n=0, asynchronously:
- state = IDLE.
- go, irq, avs_readdata, busy, irq_en, done_flag, timeout_flag = 0.
- INDEX, A, B, R registers = 0.
- counter = 0.
REQ-018 Reset asserted mid-operation SHALL drop go within the same cycle, with no R capture.

Verification
REQ-019 Reset, then read every address -> all read 0; go=0; irq=0.
REQ-020 Write A="abcdefgh" (word4=0x61626364, word5=0x65666768), INDEX=1, start; model responds done=1 three cycles after go and holds done until go=0, with Result="ABCDEFGH" -> go high exactly 4 cycles; R words read 0x41424344 and 0x45464748; STATUS=0x1.
REQ-021 With irq_en=1 and a completed operation -> irq=1; write STATUS=0x1 -> irq=0 on the next cycle.
REQ-022 Model never asserts done -> after 1024 RUN cycles go=0, STATUS=0x2, R unchanged from its prior value.
REQ-023 While busy, write A word4=0xFFFFFFFF and start again -> A output unchanged, no second RUN entry.
REQ-024 Assert reset_n=0 while go=1 -> go=0 immediately; after release, STATUS=0 and R=0.

Source files
------------

// File: rtl/string_hw_host_if_if.sv
// Host-side register bus for the string accelerator host interface.
// The master drives address/strobes/data and the slave returns registered read data.
interface string_hw_host_if_if;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/string_hw_host_if.sv
// Memory-mapped host interface for a string accelerator.
// Holds the operand, index and result registers, sequences the go/done handshake
// with a timeout, and raises a level interrupt on completion or timeout.
module string_hw_host_if #(
  parameter int unsigned MAX_BLOCKS     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  string_hw_host_if_if.slave            avs,
  output logic                          irq,
  output logic                          go,
  output logic [3:0]                    index,
  output logic [MAX_BLOCKS*4-1:0][7:0]  A,
  output logic [MAX_BLOCKS*4-1:0][7:0]  B,
  input  logic                          done,
  input  logic [MAX_BLOCKS*4-1:0][7:0]  Result
);

  localparam int unsigned NumBytes = MAX_BLOCKS * 4;
  localparam int unsigned ABase    = 4;
  localparam int unsigned BBase    = 4 + MAX_BLOCKS;
  localparam int unsigned RBase    = 4 + 2 * MAX_BLOCKS;
  localparam int unsigned CntW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRun, StRelease} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       irq_en_q, irq_en_d;
  logic                       done_flag_q, done_flag_d;
  logic                       to_flag_q, to_flag_d;
  logic                       irq_q, irq_d;
  logic [3:0]                 index_q, index_d;
  logic [NumBytes-1:0][7:0]   a_q, a_d;
  logic [NumBytes-1:0][7:0]   b_q, b_d;
  logic [NumBytes-1:0][7:0]   r_q, r_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [31:0]                rdata;
  logic [31:0]                addr_w;
  logic                       busy;
  logic                       wr;

  assign addr_w = {28'b0, avs.avs_address};
  assign busy   = (state_q != StIdle);
  assign wr     = avs.avs_write;

  // Next-state for the FSM, counter, flags and register file.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    irq_en_d    = irq_en_q;
    done_flag_d = done_flag_q;
    to_flag_d   = to_flag_q;
    index_d     = index_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;

    // Software writes; operand and index registers are frozen while busy.
    if (wr && addr_w == 32'd0) irq_en_d = avs.avs_writedata[1];
    if (wr && addr_w == 32'd1) begin
      if (avs.avs_writedata[0]) done_flag_d = 1'b0;
      if (avs.avs_writedata[1]) to_flag_d   = 1'b0;
    end
    if (wr && !busy && addr_w == 32'd2) index_d = avs.avs_writedata[3:0];
    for (int unsigned k = 0; k < MAX_BLOCKS; k++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        if (wr && !busy && addr_w == ABase + k) a_d[4*k+j] = avs.avs_writedata[31-8*j -: 8];
        if (wr && !busy && addr_w == BBase + k) b_d[4*k+j] = avs.avs_writedata[31-8*j -: 8];
      end
    end

    // Hardware flag sets come last so they win over a same-cycle clear.
    unique case (state_q)
      StIdle: begin
        if (wr && addr_w == 32'd0 && avs.avs_writedata[0]) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d     = StRelease;
          r_d         = Result;
          done_flag_d = 1'b1;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StRelease;
          to_flag_d = 1'b1;
        end
      end
      StRelease: begin
        if (!done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    irq_d = irq_en_d & (done_flag_d | to_flag_d);
  end

  // Read mux; readdata holds its value between reads.
  always_comb begin
    rdata = '0;
    if (addr_w == 32'd0) rdata = {30'b0, irq_en_q, busy};
    if (addr_w == 32'd1) rdata = {30'b0, to_flag_q, done_flag_q};
    if (addr_w == 32'd2) rdata = {28'b0, index_q};
    for (int unsigned k = 0; k < MAX_BLOCKS; k++) begin
      if (addr_w == ABase + k) rdata = {a_q[4*k], a_q[4*k+1], a_q[4*k+2], a_q[4*k+3]};
      if (addr_w == BBase + k) rdata = {b_q[4*k], b_q[4*k+1], b_q[4*k+2], b_q[4*k+3]};
      if (addr_w == RBase + k) rdata = {r_q[4*k], r_q[4*k+1], r_q[4*k+2], r_q[4*k+3]};
    end
    rdata_d = avs.avs_read ? rdata : rdata_q;
  end

  // State and register update with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      irq_en_q    <= 1'b0;
      done_flag_q <= 1'b0;
      to_flag_q   <= 1'b0;
      irq_q       <= 1'b0;
      index_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      irq_en_q    <= irq_en_d;
      done_flag_q <= done_flag_d;
      to_flag_q   <= to_flag_d;
      irq_q       <= irq_d;
      index_q     <= index_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      rdata_q     <= rdata_d;
    end
  end

  // go is decoded from state so an asynchronous reset drops it immediately.
  assign go               = (state_q == StRun);
  assign irq              = irq_q;
  assign index            = index_q;
  assign A                = a_q;
  assign B                = b_q;
  assign avs.avs_readdata = rdata_q;

endmodule

// File: tb/tb_string_hw_host_if.sv
// Directed bench for string_hw_host_if: register table plus handshake sequences
// against a small accelerator model driven from the falling clock edge.
module tb_string_hw_host_if;

  logic              clk;
  logic              reset_n;
  logic              irq;
  logic              go;
  logic [3:0]        index;
  logic [7:0][7:0]   A;
  logic [7:0][7:0]   B;
  logic              done;
  logic [7:0][7:0]   Result;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0: never done, 1: done on 4th go cycle, 2: done on 1024th go cycle
  int go_cnt = 0;
  int last_len = 0;
  int runs = 0;

  string_hw_host_if_if bus ();

  string_hw_host_if #(
    .MAX_BLOCKS     (2),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .irq     (irq),
    .go      (go),
    .index   (index),
    .A       (A),
    .B       (B),
    .done    (done),
    .Result  (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accelerator model: counts go cycles, raises done per mode, holds it until go drops.
  always @(negedge clk) begin
    if (go) begin
      if (go_cnt == 0) runs = runs + 1;
      go_cnt = go_cnt + 1;
      done = (mode == 1 && go_cnt >= 4) || (mode == 2 && go_cnt >= 1024);
    end else begin
      if (go_cnt != 0) last_len = go_cnt;
      go_cnt = 0;
      done   = 1'b0;
    end
  end

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vec[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(posedge clk); #1;
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(posedge clk); #1;
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Waits for go and done both low, then one more cycle for RELEASE -> IDLE.
  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!go && !done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle actual=timeout required=idle");
    end
    cyc(1);
  endtask

  logic [31:0] d;
  int          r0;

  initial begin
    vec[0]  = '{"index_wr",   4'd2,  32'hFFFF_FFF5, 32'h0000_0005};
    vec[1]  = '{"a_word0",    4'd4,  32'h6162_6364, 32'h6162_6364};
    vec[2]  = '{"a_word1",    4'd5,  32'h6566_6768, 32'h6566_6768};
    vec[3]  = '{"b_word0",    4'd6,  32'h1122_3344, 32'h1122_3344};
    vec[4]  = '{"b_word1",    4'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vec[5]  = '{"unmapped3",  4'd3,  32'hFFFF_FFFF, 32'h0000_0000};
    vec[6]  = '{"r_readonly", 4'd8,  32'h1234_5678, 32'h0000_0000};
    vec[7]  = '{"unmapped12", 4'd12, 32'hA5A5_A5A5, 32'h0000_0000};
    vec[8]  = '{"status_w1c", 4'd1,  32'h0000_0003, 32'h0000_0000};
    vec[9]  = '{"irq_en_set", 4'd0,  32'h0000_0002, 32'h0000_0002};
    vec[10] = '{"irq_en_clr", 4'd0,  32'h0000_0000, 32'h0000_0000};

    reset_n = 1'b0;
    bus.avs_address = '0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read = 1'b0;
    Result = '0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);

    // Reset state: every address reads zero, outputs idle.
    for (int a = 0; a < 16; a++) begin
      rd(a[3:0], d);
      chk($sformatf("reset_rd%0d", a), 64'(d), 64'h0);
    end
    chk("reset_go", 64'(go), 64'h0);
    chk("reset_irq", 64'(irq), 64'h0);

    // Register write/readback table.
    for (int i = 0; i < 11; i++) begin
      wr(vec[i].addr, vec[i].wdata);
      rd(vec[i].addr, d);
      chk(vec[i].name, 64'(d), 64'(vec[i].exp));
    end
    chk("a_port", A, 64'h6867_6665_6463_6261);
    chk("b_port", B, 64'hEFBE_ADDE_4433_2211);
    chk("index_port", 64'(index), 64'h5);

    // Normal operation: done on the 4th go cycle.
    wr(4'd2, 32'h1);
    Result = 64'h4847_4645_4443_4241;
    mode = 1;
    wr(4'd0, 32'h1);
    wait_idle(100);
    chk("op_go_len", 64'(last_len), 64'd4);
    rd(4'd8, d); chk("op_r0", 64'(d), 64'h4142_4344);
    rd(4'd9, d); chk("op_r1", 64'(d), 64'h4546_4748);
    rd(4'd1, d); chk("op_status", 64'(d), 64'h1);
    rd(4'd0, d); chk("op_ctrl", 64'(d), 64'h0);
    chk("op_index", 64'(index), 64'h1);
    chk("op_irq_off", 64'(irq), 64'h0);

    // Interrupt enable and clear.
    wr(4'd0, 32'h2);
    chk("irq_on", 64'(irq), 64'h1);
    wr(4'd1, 32'h1);
    chk("irq_clr", 64'(irq), 64'h0);
    rd(4'd1, d); chk("status_clr", 64'(d), 64'h0);

    // Timeout: no done, R must keep its previous contents.
    Result = 64'h7A7A_7A7A_7A7A_7A7A;
    mode = 0;
    wr(4'd0, 32'h3);
    wait_idle(1200);
    chk("to_go_len", 64'(last_len), 64'd1024);
    rd(4'd1, d); chk("to_status", 64'(d), 64'h2);
    rd(4'd8, d); chk("to_r0", 64'(d), 64'h4142_4344);
    rd(4'd9, d); chk("to_r1", 64'(d), 64'h4546_4748);
    chk("to_irq", 64'(irq), 64'h1);
    wr(4'd1, 32'h2);
    rd(4'd1, d); chk("to_clr", 64'(d), 64'h0);

    // done in the same cycle as the timeout: done wins.
    Result = 64'h3837_3635_3433_3231;
    mode = 2;
    wr(4'd0, 32'h3);
    wait_idle(1200);
    chk("tie_go_len", 64'(last_len), 64'd1024);
    rd(4'd1, d); chk("tie_status", 64'(d), 64'h1);
    rd(4'd8, d); chk("tie_r0", 64'(d), 64'h3132_3334);
    rd(4'd9, d); chk("tie_r1", 64'(d), 64'h3536_3738);

    // Start accepted with done_flag still set; writes while busy are ignored.
    Result = 64'h4847_4645_4443_4241;
    mode = 1;
    r0 = runs;
    wr(4'd0, 32'h3);
    wr(4'd4, 32'hFFFF_FFFF);
    wr(4'd0, 32'h3);
    chk("busy_go", 64'(go), 64'h1);
    rd(4'd0, d); chk("busy_ctrl", 64'(d), 64'h3);
    wait_idle(100);
    cyc(4);
    chk("busy_runs", 64'(runs - r0), 64'd1);
    chk("busy_len", 64'(last_len), 64'd4);
    chk("busy_a_port", A, 64'h6867_6665_6463_6261);
    rd(4'd4, d); chk("busy_a_word", 64'(d), 64'h6162_6364);
    rd(4'd8, d); chk("busy_r0", 64'(d), 64'h4142_4344);
    rd(4'd1, d); chk("busy_status", 64'(d), 64'h1);

    // STATUS clear in the same cycle done_flag is set: flag stays set.
    wr(4'd1, 32'h3);
    wr(4'd0, 32'h1);
    cyc(3);
    wr(4'd1, 32'h1);
    wait_idle(100);
    rd(4'd1, d); chk("setclr_status", 64'(d), 64'h1);

    // Reset mid-operation.
    wr(4'd1, 32'h3);
    mode = 0;
    wr(4'd0, 32'h1);
    cyc(5);
    chk("rst_go_before", 64'(go), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_go_now", 64'(go), 64'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    rd(4'd1, d); chk("rst_status", 64'(d), 64'h0);
    rd(4'd8, d); chk("rst_r0", 64'(d), 64'h0);
    rd(4'd9, d); chk("rst_r1", 64'(d), 64'h0);
    chk("rst_a_port", A, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
